// File: rtl/mips_pkg.sv
// Shared MIPS-I definitions for the instruction encoder: the abstract
// instruction kinds, the opcode, funct, REGIMM and COP0 field codes, and the
// encode function that packs one instruction into a 32-bit word.
package mips_pkg;

  typedef enum logic [5:0] {
    K_SLL = 6'd0, K_SRL, K_SRA, K_SLLV, K_SRLV, K_SRAV, K_JR, K_JALR,
    K_SYSCALL, K_BREAK, K_MFHI, K_MTHI, K_MFLO, K_MTLO,
    K_MULT, K_MULTU, K_DIV, K_DIVU,
    K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU,
    K_BLTZ, K_BGEZ, K_J, K_JAL, K_BEQ, K_BNE, K_BLEZ, K_BGTZ,
    K_ADDI, K_ADDIU, K_SLTI, K_SLTIU, K_ANDI, K_ORI, K_XORI, K_LUI,
    K_LB, K_LH, K_LW, K_LBU, K_LHU, K_SB, K_SH, K_SW,
    K_MFC0, K_MTC0, K_ERET
  } kind_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_COP0 = 6'h10;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C, FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return {OP_SPECIAL, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Codes above K_ERET fall to the default and are reported as illegal.
  function automatic enc_t encode(input logic [5:0] kind, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [4:0] sa, input logic [25:0] imm);
    enc_t e;
    e.legal = 1'b1;
    e.word  = '0;
    case (kind)
      K_SLL:     e.word = r_word(5'd0, rt, rd, sa, FN_SLL);
      K_SRL:     e.word = r_word(5'd0, rt, rd, sa, FN_SRL);
      K_SRA:     e.word = r_word(5'd0, rt, rd, sa, FN_SRA);
      K_SLLV:    e.word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      K_SRLV:    e.word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      K_SRAV:    e.word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      K_JR:      e.word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      K_JALR:    e.word = r_word(rs, 5'd0, rd, 5'd0, FN_JALR);
      K_SYSCALL: e.word = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
      K_BREAK:   e.word = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_BREAK);
      K_MFHI:    e.word = r_word(5'd0, 5'd0, rd, 5'd0, FN_MFHI);
      K_MFLO:    e.word = r_word(5'd0, 5'd0, rd, 5'd0, FN_MFLO);
      K_MTHI:    e.word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_MTHI);
      K_MTLO:    e.word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_MTLO);
      K_MULT:    e.word = r_word(rs, rt, 5'd0, 5'd0, FN_MULT);
      K_MULTU:   e.word = r_word(rs, rt, 5'd0, 5'd0, FN_MULTU);
      K_DIV:     e.word = r_word(rs, rt, 5'd0, 5'd0, FN_DIV);
      K_DIVU:    e.word = r_word(rs, rt, 5'd0, 5'd0, FN_DIVU);
      K_ADD:     e.word = r_word(rs, rt, rd, sa, FN_ADD);
      K_ADDU:    e.word = r_word(rs, rt, rd, sa, FN_ADDU);
      K_SUB:     e.word = r_word(rs, rt, rd, sa, FN_SUB);
      K_SUBU:    e.word = r_word(rs, rt, rd, sa, FN_SUBU);
      K_AND:     e.word = r_word(rs, rt, rd, sa, FN_AND);
      K_OR:      e.word = r_word(rs, rt, rd, sa, FN_OR);
      K_XOR:     e.word = r_word(rs, rt, rd, sa, FN_XOR);
      K_NOR:     e.word = r_word(rs, rt, rd, sa, FN_NOR);
      K_SLT:     e.word = r_word(rs, rt, rd, sa, FN_SLT);
      K_SLTU:    e.word = r_word(rs, rt, rd, sa, FN_SLTU);
      K_BLTZ:    e.word = i_word(OP_REGIMM, rs, RT_BLTZ, imm[15:0]);
      K_BGEZ:    e.word = i_word(OP_REGIMM, rs, RT_BGEZ, imm[15:0]);
      K_J:       e.word = {OP_J, imm};
      K_JAL:     e.word = {OP_JAL, imm};
      K_BEQ:     e.word = i_word(OP_BEQ, rs, rt, imm[15:0]);
      K_BNE:     e.word = i_word(OP_BNE, rs, rt, imm[15:0]);
      K_BLEZ:    e.word = i_word(OP_BLEZ, rs, 5'd0, imm[15:0]);
      K_BGTZ:    e.word = i_word(OP_BGTZ, rs, 5'd0, imm[15:0]);
      K_ADDI:    e.word = i_word(OP_ADDI, rs, rt, imm[15:0]);
      K_ADDIU:   e.word = i_word(OP_ADDIU, rs, rt, imm[15:0]);
      K_SLTI:    e.word = i_word(OP_SLTI, rs, rt, imm[15:0]);
      K_SLTIU:   e.word = i_word(OP_SLTIU, rs, rt, imm[15:0]);
      K_ANDI:    e.word = i_word(OP_ANDI, rs, rt, imm[15:0]);
      K_ORI:     e.word = i_word(OP_ORI, rs, rt, imm[15:0]);
      K_XORI:    e.word = i_word(OP_XORI, rs, rt, imm[15:0]);
      K_LUI:     e.word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
      K_LB:      e.word = i_word(OP_LB, rs, rt, imm[15:0]);
      K_LH:      e.word = i_word(OP_LH, rs, rt, imm[15:0]);
      K_LW:      e.word = i_word(OP_LW, rs, rt, imm[15:0]);
      K_LBU:     e.word = i_word(OP_LBU, rs, rt, imm[15:0]);
      K_LHU:     e.word = i_word(OP_LHU, rs, rt, imm[15:0]);
      K_SB:      e.word = i_word(OP_SB, rs, rt, imm[15:0]);
      K_SH:      e.word = i_word(OP_SH, rs, rt, imm[15:0]);
      K_SW:      e.word = i_word(OP_SW, rs, rt, imm[15:0]);
      K_MFC0:    e.word = {OP_COP0, RS_MFC0, rt, rd, 11'd0};
      K_MTC0:    e.word = {OP_COP0, RS_MTC0, rt, rd, 11'd0};
      K_ERET:    e.word = ERET_WORD;
      default:   e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mips_ins_fifo.sv
// Synchronous FIFO holding encoded words between the encoder and instruction
// memory. Flush empties it and suppresses any push on the same edge; the
// storage is cleared on reset so the head reads zero out of reset.
module mips_ins_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage.
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_ins_enc.sv
// MIPS-I instruction encoder / program loader. Accepts abstract instructions,
// packs them into 32-bit words, queues them and writes them to instruction
// memory at an auto-incrementing address. Illegal kinds are consumed but only
// counted. Optional running checksum of written words: MIPS_INS_ENC_CHKSUM_EN.
module mips_ins_enc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [25:0]       in_imm,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ready,
  output logic              err,
  output logic [7:0]        err_cnt,
`ifdef MIPS_INS_ENC_CHKSUM_EN
  output logic [31:0]       chksum,
`endif
  output logic [ADDR_W:0]   wr_cnt
);
  enc_t              enc;
  logic              accept, push, wr_done, fifo_full, fifo_empty;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  assign enc      = encode(in_kind, in_rs, in_rt, in_rd, in_sa, in_imm);
  assign in_ready = !fifo_full && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc.legal;
  assign im_we    = !fifo_empty;
  assign wr_done  = im_we && im_ready;

  mips_ins_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (wr_done),
    .flush (flush),
    .din   (enc.word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (im_wdata)
  );

  // Address counter (load beats increment), write count and error tracking.
  always_comb begin
    im_addr_d = im_addr_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (load_base)    im_addr_d = base_addr;
    else if (wr_done) im_addr_d = im_addr_q + 1'b1;
    if (wr_done) wr_cnt_d = wr_cnt_q + 1'b1;
    if (accept && !enc.legal) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_addr_q <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      im_addr_q <= im_addr_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign im_addr = im_addr_q;
  assign wr_cnt  = wr_cnt_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

`ifdef MIPS_INS_ENC_CHKSUM_EN
  logic [31:0] chksum_q, chksum_d;
  logic [63:0] rot_w;

  // Fold each written word in, rotated by the low address bits; load clears.
  always_comb begin
    rot_w    = {im_wdata, im_wdata} << im_addr_q[4:0];
    chksum_d = chksum_q;
    if (load_base)    chksum_d = '0;
    else if (wr_done) chksum_d = chksum_q ^ rot_w[63:32];
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chksum_q <= '0;
    else        chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_mips_ins_enc.sv
module tb_mips_ins_enc;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        in_kind = '0;
  logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
  logic [25:0]       in_imm = '0;
  logic              load_base = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              flush = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              im_ready = 1'b0;
  logic              err;
  logic [7:0]        err_cnt;
  logic [ADDR_W:0]   wr_cnt;
`ifdef MIPS_INS_ENC_CHKSUM_EN
  logic [31:0]       chksum;
`endif

  always #5 clk = ~clk;

  mips_ins_enc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .load_base(load_base), .base_addr(base_addr), .flush(flush),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_ready(im_ready),
    .err(err), .err_cnt(err_cnt),
`ifdef MIPS_INS_ENC_CHKSUM_EN
    .chksum(chksum),
`endif
    .wr_cnt(wr_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [31:0]       mq[$];
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W:0]   m_wcnt;
  logic              m_err;
  logic [7:0]        m_ecnt;
  logic [31:0]       m_ck;
  int                n_acc = 0;
  int                dut_acc = 0;
  logic [31:0]       wlog_d[$];
  logic [ADDR_W-1:0] wlog_a[$];

  // Instruction tables, indexed by kind code.
  logic [5:0] fn_tab [28] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                              6'h0C, 6'h0D, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19,
                              6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2A, 6'h2B};
  // Kept R-type fields, bit order {rs, rt, rd, sa}.
  logic [3:0] keep_tab [28] = '{4'b0111, 4'b0111, 4'b0111, 4'b1110, 4'b1110, 4'b1110,
                                4'b1000, 4'b1010, 4'b0000, 4'b0000, 4'b0010, 4'b1000,
                                4'b0010, 4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
                                4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                4'b1111, 4'b1111, 4'b1111, 4'b1111};
  logic [5:0] ls_op [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  function automatic logic [31:0] ref_word(int k, logic [4:0] rs, logic [4:0] rt,
                                           logic [4:0] rd, logic [4:0] sa, logic [25:0] imm);
    logic [31:0] w;
    logic [3:0]  m;
    w = '0;
    if (k < 28) begin
      m = keep_tab[k];
      w = {6'd0, m[3] ? rs : 5'd0, m[2] ? rt : 5'd0, m[1] ? rd : 5'd0, m[0] ? sa : 5'd0, fn_tab[k]};
    end else if (k < 30) begin
      w = {6'd1, rs, 5'(k - 28), imm[15:0]};
    end else if (k < 32) begin
      w = {6'(k - 28), imm};
    end else if (k < 44) begin
      if (k == 34 || k == 35) rt = 5'd0;
      if (k == 43) rs = 5'd0;
      w = {6'(k - 28), rs, rt, imm[15:0]};
    end else if (k < 52) begin
      w = {ls_op[k - 44], rs, rt, imm[15:0]};
    end else if (k < 54) begin
      w = {6'h10, 5'(4 * (k - 52)), rt, rd, 11'd0};
    end else begin
      w = 32'h4200_0018;
    end
    return w;
  endfunction

  function automatic logic [31:0] rotl(logic [31:0] v, int s);
    for (int i = 0; i < s; i++) v = {v[30:0], v[31]};
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs with the model, advance the model, cross the edge.
  task automatic tick();
    logic m_rdy, acc, wr;
    #1;
    m_rdy = (mq.size() < DEPTH) && !flush;
    chk("in_ready", in_ready, m_rdy);
    chk("im_we", im_we, mq.size() > 0);
    chk("im_addr", im_addr, m_addr);
    chk("wr_cnt", wr_cnt, m_wcnt);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_ecnt);
    if (mq.size() > 0) chk("im_wdata", im_wdata, mq[0]);
`ifdef MIPS_INS_ENC_CHKSUM_EN
    chk("chksum", chksum, m_ck);
`endif
    if (in_valid && in_ready) dut_acc++;
    acc = in_valid && m_rdy;
    wr  = (mq.size() > 0) && im_ready;
    if (acc) n_acc++;
    if (wr) begin
      wlog_d.push_back(im_wdata);
      wlog_a.push_back(im_addr);
    end
    if (load_base)  m_ck = '0;
    else if (wr)    m_ck = m_ck ^ rotl(mq[0], int'(m_addr[4:0]));
    if (load_base)  m_addr = base_addr;
    else if (wr)    m_addr = m_addr + 1'b1;
    if (wr) m_wcnt = m_wcnt + 1'b1;
    if (acc && in_kind > 6'd54) begin
      m_err = 1'b1;
      if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
    end
    if (flush) mq.delete();
    else begin
      if (wr) void'(mq.pop_front());
      if (acc && in_kind <= 6'd54)
        mq.push_back(ref_word(int'(in_kind), in_rs, in_rt, in_rd, in_sa, in_imm));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one instruction until it is accepted (bounded); leaves in_valid high.
  task automatic send(int k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                      logic [4:0] sa, logic [25:0] imm);
    int a0;
    a0 = n_acc;
    in_valid = 1'b1; in_kind = 6'(k);
    in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa; in_imm = imm;
    for (int i = 0; i < 30 && n_acc == a0; i++) tick();
    if (n_acc == a0) chk("send_timeout", 64'(n_acc - a0), 64'd1);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0; load_base = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
`ifdef MIPS_INS_ENC_CHKSUM_EN
    chk("rst_chksum", chksum, 0);
`endif
    mq.delete();
    m_addr = '0; m_wcnt = '0; m_err = 1'b0; m_ecnt = '0; m_ck = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    wlog_d.delete();
    wlog_a.delete();
  endtask

  task automatic chk_log(int i, logic [ADDR_W-1:0] a, logic [31:0] d);
    if (wlog_d.size() <= i) chk("log_size", wlog_d.size(), i + 1);
    else begin
      chk("log_addr", wlog_a[i], a);
      chk("log_data", wlog_d[i], d);
    end
  endtask

  initial begin
    int a0;
    do_reset();

    // Single addu with memory ready.
    im_ready = 1'b1;
    clear_log();
    send(19, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
    idle(3);
    chk("addu_n", wlog_d.size(), 1);
    chk_log(0, 10'd0, 32'h0022_1821);
    chk("addu_addr", im_addr, 1);
    chk("addu_wr_cnt", wr_cnt, 1);

    // Back-to-back stream from address 0.
    do_reset();
    im_ready = 1'b1;
    clear_log();
    send(41, 5'd0, 5'd5, 5'd0, 5'd0, 26'h1234);
    send(46, 5'd29, 5'd4, 5'd0, 5'd0, 26'd8);
    send(51, 5'd29, 5'd4, 5'd0, 5'd0, 26'd8);
    send(0, 5'd7, 5'd3, 5'd2, 5'd4, 26'd0);
    idle(4);
    chk_log(0, 10'd0, 32'h3405_1234);
    chk_log(1, 10'd1, 32'h8FA4_0008);
    chk_log(2, 10'd2, 32'hAFA4_0008);
    chk_log(3, 10'd3, 32'h0003_1100);

    // Memory stalled: only DEPTH words accepted, head stays put.
    im_ready = 1'b0;
    clear_log();
    a0 = dut_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_kind = 6'd37; in_rs = 5'd0; in_rt = 5'(i + 1); in_rd = 5'd0; in_sa = 5'd0;
      in_imm = 26'(i);
      tick();
    end
    chk("stall_accepts", 64'(dut_acc - a0), 64'd4);
    chk("stall_head", im_wdata, 32'h2401_0000);
    chk("stall_no_write", wlog_d.size(), 0);
    im_ready = 1'b1;
    idle(6);
    chk("stall_n", wlog_d.size(), 4);
    chk_log(0, 10'd4, 32'h2401_0000);
    chk_log(1, 10'd5, 32'h2402_0001);
    chk_log(2, 10'd6, 32'h2403_0002);
    chk_log(3, 10'd7, 32'h2404_0003);

    // Jumps, eret and branches.
    clear_log();
    send(30, 5'd0, 5'd0, 5'd0, 5'd0, 26'h010_0000);
    send(54, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0);
    send(32, 5'd1, 5'd2, 5'd0, 5'd0, 26'h0FFFF);
    send(29, 5'd1, 5'd0, 5'd0, 5'd0, 26'd4);
    idle(4);
    chk_log(0, 10'd8, 32'h0810_0000);
    chk_log(1, 10'd9, 32'h4200_0018);
    chk_log(2, 10'd10, 32'h1022_FFFF);
    chk_log(3, 10'd11, 32'h0421_0004);

    // Illegal kinds: consumed, counted, saturating.
    clear_log();
    send(63, 5'd1, 5'd2, 5'd3, 5'd4, 26'd5);
    idle(3);
    chk("ill_no_write", wlog_d.size(), 0);
    chk("ill_err", err, 1);
    chk("ill_err_cnt", err_cnt, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_kind = 6'(55 + (i % 9));
      tick();
    end
    idle(1);
    chk("ill_sat", err_cnt, 255);

    // Reset in the middle of a burst.
    im_ready = 1'b0;
    send(19, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
    send(20, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0);
    send(22, 5'd7, 5'd8, 5'd9, 5'd0, 26'd0);
    in_valid = 1'b0;
    im_ready = 1'b1;
    tick();
    do_reset();
    idle(2);

    // Address wrap after loading the top address.
    load_base = 1'b1; base_addr = 10'h3FF;
    tick();
    load_base = 1'b0;
    clear_log();
    send(41, 5'd0, 5'd1, 5'd0, 5'd0, 26'h0001);
    send(41, 5'd0, 5'd2, 5'd0, 5'd0, 26'h0002);
    idle(3);
    chk_log(0, 10'h3FF, 32'h3401_0001);
    chk_log(1, 10'h000, 32'h3402_0002);

    // Flush with words queued and memory stalled.
    im_ready = 1'b0;
    send(37, 5'd0, 5'd1, 5'd0, 5'd0, 26'd1);
    send(37, 5'd0, 5'd2, 5'd0, 5'd0, 26'd2);
    send(37, 5'd0, 5'd3, 5'd0, 5'd0, 26'd3);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_we", im_we, 0);
    chk("flush_wr_cnt", wr_cnt, 2);

    // Flush coinciding with a completed write.
    send(37, 5'd0, 5'd4, 5'd0, 5'd0, 26'd4);
    send(37, 5'd0, 5'd5, 5'd0, 5'd0, 26'd5);
    in_valid = 1'b0;
    im_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(2);
    chk("flushwr_wr_cnt", wr_cnt, 3);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom % 3) != 0;
      in_kind   = (($urandom % 10) == 0) ? 6'(55 + $urandom % 9) : 6'($urandom % 55);
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_sa     = 5'($urandom);
      in_imm    = 26'($urandom);
      im_ready  = ($urandom % 4) != 0;
      load_base = ($urandom % 40) == 0;
      base_addr = 10'($urandom);
      flush     = ($urandom % 50) == 0;
      tick();
    end
    load_base = 1'b0;
    flush = 1'b0;
    im_ready = 1'b1;
    idle(DEPTH + 3);
    chk("drain_we", im_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_ins_enc.md
Name: mips_ins_enc

Overview:
- Instruction encoder; the producing end of the 32-bit MIPS instruction word that the control decoder consumes.
- Accepts an abstract instruction (kind code plus register, shamt and immediate fields) over a valid/ready handshake.
- Packs each instruction into a 32-bit MIPS-I word, buffers it in a small FIFO, and writes it to instruction memory at an auto-incrementing address.
- Used as the program loader for self-test and boot.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 4, output FIFO depth in words; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  encoder can accept.
- in_kind  in  6  instruction kind code (package enum).
- in_rs, in_rt, in_rd, in_sa  in  5 each  register and shamt fields.
- in_imm  in  26  immediate: low 16 bits for I-type and branches, all 26 bits for J-type.
- load_base  in  1  load the address counter.
- base_addr  in  ADDR_W  value loaded by load_base.
- flush  in  1  discard all buffered words.
- im_we  out  1  memory write request.
- im_addr  out  ADDR_W  memory write word address.
- im_wdata  out  32  encoded instruction word.
- im_ready  in  1  memory accepts the write this cycle.
- err  out  1  sticky: an illegal kind was seen.
- err_cnt  out  8  count of illegal kinds, saturating.
- wr_cnt  out  ADDR_W+1  words written since reset, wrapping.

Behaviour:
- Reset (asynchronous, rst_n=0): FIFO empty; im_we=0, im_addr=0, im_wdata=0, err=0, err_cnt=0, wr_cnt=0; in_ready=1 once released.
- Input handshake completes when in_valid && in_ready.
  - in_ready = !full && !flush.
  - Encoding is combinational on the inputs; the word is pushed on the same edge.
  - Earliest im_we is the cycle after acceptance (latency 1).
- Output handshake: im_we = FIFO not empty; im_wdata = FIFO head.
  - A write completes when im_we && im_ready; on that edge pop, im_addr += 1 (wraps modulo 2^ADDR_W) and wr_cnt += 1.
  - im_addr and im_wdata stay stable while im_we=1 && im_ready=0.
- Simultaneous push and pop: allowed when the FIFO is non-empty and not full; count unchanged.
  - When full, in_ready=0, even if a pop occurs in the same cycle.
- Encodings (fields not listed are 0):
  - R-type: {000000, rs, rt, rd, sa, funct}. Shifts sll/srl/sra force rs=0. sllv/srlv/srav force sa=0.
  - mult/div family: rd=0, sa=0. mfhi/mflo: rs=rt=sa=0. mthi/mtlo/jr: only rs is kept.
  - jalr: rt=0, rd from in_rd. syscall/break: {000000, 20'b0, funct}.
  - I-type and beq/bne/blez/bgtz: {op, rs, rt, imm[15:0]}. blez/bgtz force rt=0. lui forces rs=0.
  - bltz/bgez: {000001, rs, 00000/00001, imm[15:0]}.
  - j/jal: {op, imm[25:0]}.
  - mfc0/mtc0: {010000, 00000/00100, rt, rd, 11'b0}. eret = 0x42000018.
- Illegal kind (code outside the enum):
  - The handshake still completes; nothing is pushed.
  - err is set; err_cnt increments and saturates at 255.
- load_base: im_addr <= base_addr at the next edge.
  - If a write completes on the same edge, load wins; no increment.
  - FIFO contents are unaffected.
- flush: FIFO emptied at the next edge; im_we=0 the following cycle.
  - A write completing on the same edge still counts (addr and wr_cnt advance).
  - No push on the flush edge, since in_ready=0.
- Reset asserted mid-operation: immediate return to reset values; buffered words are lost.

Optional Feature:
- Macro MIPS_INS_ENC_CHKSUM_EN.
- When defined: extra output chksum (32 bits), reset 0. On every completed write, chksum <= chksum ^ {im_wdata rotated left by im_addr[4:0]}. flush does not clear it; load_base clears it.
- When undefined: the port is absent and the logic is removed. All other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - the kind enum (55 codes, 0..54);
  - opcode constants (sw=101011, sh=101001, sb=101000, lw=100011, …);
  - funct constants, REGIMM rt codes and COP0 rs codes.
- Sub-module mips_ins_fifo: parameterised synchronous FIFO with push, pop, flush, full, empty and head.
- The encode function is a case on kind, in the package.

Test Plan:
- Reset, then accept addu rs=1 rt=2 rd=3 with im_ready=1 → im_we at cycle+1, im_addr=0, im_wdata=0x00221821; then im_addr=1, wr_cnt=1.
- Back-to-back: ori rt=5 imm=0x1234, lw rs=29 rt=4 imm=8, sw same fields, sll rt=3 rd=2 sa=4 with rs=7 → 0x34051234, 0x8FA40008, 0xAFA40008, 0x00031100 at addresses 0..3.
- im_ready=0 and 6 offers with DEPTH=4 → in_ready drops after 4 accepts; im_wdata holds the first word. Release im_ready → all 4 words written in order with no loss or duplication.
- j imm=0x0100000, eret, beq rs=1 rt=2 imm=0xFFFF, bgez rs=1 imm=4 → 0x08100000, 0x42000018, 0x1022FFFF, 0x04210004.
- in_kind=63 → no write, err=1, err_cnt=1. Then 300 illegal kinds → err_cnt=255.
- Boundaries: load_base base=2^ADDR_W−1 then two writes → addresses 0x3FF, 0x000. flush with 3 words queued and im_ready=0 → im_we=0 after one cycle, wr_cnt unchanged. rst_n pulse mid-burst → all outputs return to 0 immediately.
